// File: rtl/exhaustive_checker.sv
// Response checker for an exhaustive stimulus sweep: golden-table compare, coverage, mismatch stats.
// Optional stimulus-order check compiled in with CHECKER_SEQ_CHECK_EN.
//
// state  | meaning
// S_IDLE | waiting for start, samples ignored
// S_RUN  | accepting samples until every vector has been seen
// S_DONE | full coverage reached, results held until start
module exhaustive_checker #(
  parameter int                  N_IN  = 2,
  parameter logic [2**N_IN-1:0]  TRUTH = 4'b0110,
  parameter int                  ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             valid,
  input  logic [N_IN-1:0]  stim,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [N_IN-1:0]  first_err_vec,
  output logic             first_err_vld,
  output logic             seq_err
);

  localparam int NV = 2**N_IN;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_next;
  logic [NV-1:0]    r_cov, w_cov_next;
  logic [ERR_W-1:0] r_err_cnt, w_err_next;
  logic [N_IN-1:0]  r_first_vec;
  logic             r_first_vld;
  logic             r_pass;
  logic             w_accept, w_mismatch, w_complete;
  logic [NV-1:0]    w_onehot;

  // start always wins over a sample arriving in the same cycle
  assign w_accept   = valid && (r_state == S_RUN) && !start;
  assign w_mismatch = w_accept && (dut_out != TRUTH[stim]);
  assign w_onehot   = {{(NV-1){1'b0}}, 1'b1} << stim;

  always_comb begin
    w_cov_next   = r_cov;
    w_err_next   = r_err_cnt;
    w_state_next = r_state;
    w_complete   = 1'b0;
    if (start) begin
      w_cov_next   = '0;
      w_err_next   = '0;
      w_state_next = S_RUN;
    end else if (w_accept) begin
      w_cov_next = r_cov | w_onehot;
      if (w_mismatch && (r_err_cnt != {ERR_W{1'b1}}))
        w_err_next = r_err_cnt + {{(ERR_W-1){1'b0}}, 1'b1};
      if (&w_cov_next) begin
        w_complete   = 1'b1;
        w_state_next = S_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cov       <= '0;
      r_err_cnt   <= '0;
      r_first_vec <= '0;
      r_first_vld <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cov     <= w_cov_next;
      r_err_cnt <= w_err_next;
      if (start) begin
        r_first_vec <= '0;
        r_first_vld <= 1'b0;
        r_pass      <= 1'b0;
      end else begin
        if (w_mismatch && !r_first_vld) begin
          r_first_vec <= stim;
          r_first_vld <= 1'b1;
        end
        // pass includes the result of the completing sample itself
        if (w_complete)
          r_pass <= (w_err_next == '0);
      end
    end
  end

`ifdef CHECKER_SEQ_CHECK_EN
  logic [N_IN-1:0] r_prev;
  logic            r_have_prev;
  logic            r_seq_err;
  logic [N_IN-1:0] w_prev_inc;

  assign w_prev_inc = r_prev + {{(N_IN-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev      <= '0;
      r_have_prev <= 1'b0;
      r_seq_err   <= 1'b0;
    end else if (start) begin
      r_prev      <= '0;
      r_have_prev <= 1'b0;
      r_seq_err   <= 1'b0;
    end else if (w_accept) begin
      r_prev      <= stim;
      r_have_prev <= 1'b1;
      if (r_have_prev && (stim != w_prev_inc))
        r_seq_err <= 1'b1;
    end
  end

  assign seq_err = r_seq_err;
`else
  assign seq_err = 1'b0;
`endif

  assign busy          = (r_state == S_RUN);
  assign done          = (r_state == S_DONE);
  assign pass          = r_pass && (r_state == S_DONE);
  assign err_cnt       = r_err_cnt;
  assign first_err_vec = r_first_vec;
  assign first_err_vld = r_first_vld;

endmodule

// File: tb/tb_exhaustive_checker.sv
// Directed bench for exhaustive_checker (N_IN=2, TRUTH=XOR); a second ERR_W=2 instance covers saturation.
module tb_exhaustive_checker;

`ifdef CHECKER_SEQ_CHECK_EN
  localparam logic SEQ_EN = 1'b1;
`else
  localparam logic SEQ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       valid = 1'b0;
  logic [1:0] stim = 2'd0;
  logic       dut_out = 1'b0;

  logic       busy, done, pass, first_err_vld, seq_err;
  logic [7:0] err_cnt;
  logic [1:0] first_err_vec;

  logic       s_busy, s_done, s_pass, s_first_err_vld, s_seq_err;
  logic [1:0] s_err_cnt;
  logic [1:0] s_first_err_vec;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exhaustive_checker #(.N_IN(2), .TRUTH(4'b0110), .ERR_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .valid(valid), .stim(stim), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_vec(first_err_vec), .first_err_vld(first_err_vld), .seq_err(seq_err)
  );

  exhaustive_checker #(.N_IN(2), .TRUTH(4'b0110), .ERR_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .valid(valid), .stim(stim), .dut_out(dut_out),
    .busy(s_busy), .done(s_done), .pass(s_pass), .err_cnt(s_err_cnt),
    .first_err_vec(s_first_err_vec), .first_err_vld(s_first_err_vld), .seq_err(s_seq_err)
  );

  // one clock with the given inputs; returns #1 after the edge
  task automatic sample(input logic v, input logic [1:0] s, input logic d);
    valid = v; stim = s; dut_out = d;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic do_start(input logic v, input logic [1:0] s, input logic d);
    start = 1'b1;
    sample(v, s, d);
    start = 1'b0;
  endtask

  // flags order: {busy, done, pass, first_err_vld, seq_err}
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({busy, done, pass, first_err_vld, seq_err} !== 5'b00000 || err_cnt !== 8'd0 || first_err_vec !== 2'd0) begin
      errors++;
      $display("FAIL reset flags got %b err %0d vec %0d exp 00000 err 0 vec 0",
               {busy, done, pass, first_err_vld, seq_err}, err_cnt, first_err_vec);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    sample(1'b1, 2'd1, 1'b0);
    checks++;
    if (busy !== 1'b0 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL idle_ignores_valid got busy %b err %0d exp busy 0 err 0", busy, err_cnt);
    end
  endtask

  task automatic test_clean_sweep();
    logic exp_resp [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    do_start(1'b0, 2'd0, 1'b0);
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++;
      $display("FAIL clean_start got busy/done %b exp 10", {busy, done});
    end
    for (int i = 0; i < 4; i++) begin
      sample(1'b1, 2'(i), exp_resp[i]);
      if (i < 3) begin
        checks++;
        if ({busy, done} !== 2'b10) begin
          errors++;
          $display("FAIL clean_mid%0d got busy/done %b exp 10", i, {busy, done});
        end
      end
    end
    checks++;
    if ({busy, done, pass, first_err_vld, seq_err} !== 5'b01100 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL clean_done got flags %b err %0d exp 01100 err 0",
               {busy, done, pass, first_err_vld, seq_err}, err_cnt);
    end
    sample(1'b1, 2'd0, 1'b1);
    checks++;
    if ({busy, done, pass} !== 3'b011 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL done_hold got flags %b err %0d exp 011 err 0", {busy, done, pass}, err_cnt);
    end
  endtask

  task automatic test_single_fault();
    do_start(1'b0, 2'd0, 1'b0);
    sample(1'b1, 2'd0, 1'b0);
    sample(1'b1, 2'd1, 1'b1);
    sample(1'b1, 2'd2, 1'b1);
    sample(1'b1, 2'd3, 1'b1);
    checks++;
    if ({busy, done, pass, first_err_vld} !== 4'b0101 || err_cnt !== 8'd1 || first_err_vec !== 2'd3) begin
      errors++;
      $display("FAIL single_fault got flags %b err %0d vec %0d exp 0101 err 1 vec 3",
               {busy, done, pass, first_err_vld}, err_cnt, first_err_vec);
    end
  endtask

  task automatic test_incomplete();
    logic [1:0] seq [4] = '{2'd0, 2'd1, 2'd1, 2'd2};
    logic       rsp [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    do_start(1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      sample(1'b1, seq[i], rsp[i]);
      checks++;
      if ({busy, done} !== 2'b10) begin
        errors++;
        $display("FAIL incomplete_s%0d got busy/done %b exp 10", i, {busy, done});
      end
    end
    for (int i = 0; i < 3; i++) sample(1'b0, 2'd3, 1'b0);
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++;
      $display("FAIL incomplete_idle got busy/done %b exp 10", {busy, done});
    end
    sample(1'b1, 2'd3, 1'b0);
    checks++;
    if ({busy, done, pass, seq_err} !== {3'b011, SEQ_EN} || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL incomplete_done got flags %b err %0d exp %b err 0",
               {busy, done, pass, seq_err}, err_cnt, {3'b011, SEQ_EN});
    end
  endtask

  task automatic test_saturation();
    logic [1:0] seq [7] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
    logic       rsp [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    do_start(1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 7; i++) sample(1'b1, seq[i], rsp[i]);
    checks++;
    if (s_err_cnt !== 2'd3 || err_cnt !== 8'd7) begin
      errors++;
      $display("FAIL saturation got sat %0d wide %0d exp sat 3 wide 7", s_err_cnt, err_cnt);
    end
    checks++;
    if ({s_done, s_pass, s_first_err_vld} !== 3'b101 || s_first_err_vec !== 2'd0) begin
      errors++;
      $display("FAIL saturation_done got flags %b vec %0d exp 101 vec 0",
               {s_done, s_pass, s_first_err_vld}, s_first_err_vec);
    end
  endtask

  task automatic test_restart_and_reset();
    do_start(1'b0, 2'd0, 1'b0);
    sample(1'b1, 2'd0, 1'b1);
    sample(1'b1, 2'd1, 1'b1);
    checks++;
    if (err_cnt !== 8'd1 || first_err_vld !== 1'b1) begin
      errors++;
      $display("FAIL restart_pre got err %0d vld %b exp err 1 vld 1", err_cnt, first_err_vld);
    end
    do_start(1'b1, 2'd2, 1'b0);
    checks++;
    if ({busy, done, first_err_vld} !== 3'b100 || err_cnt !== 8'd0 || first_err_vec !== 2'd0) begin
      errors++;
      $display("FAIL restart_clear got flags %b err %0d vec %0d exp 100 err 0 vec 0",
               {busy, done, first_err_vld}, err_cnt, first_err_vec);
    end
    sample(1'b1, 2'd0, 1'b0);
    sample(1'b1, 2'd1, 1'b1);
    sample(1'b1, 2'd3, 1'b0);
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++;
      $display("FAIL restart_dropped got busy/done %b exp 10", {busy, done});
    end
    sample(1'b1, 2'd2, 1'b1);
    checks++;
    if ({busy, done, pass} !== 3'b011) begin
      errors++;
      $display("FAIL restart_done got flags %b exp 011", {busy, done, pass});
    end
    do_start(1'b0, 2'd0, 1'b0);
    sample(1'b1, 2'd0, 1'b0);
    sample(1'b1, 2'd2, 1'b1);
    sample(1'b1, 2'd1, 1'b1);
    sample(1'b1, 2'd3, 1'b1);
    checks++;
    if ({busy, done, pass} !== 3'b010 || err_cnt !== 8'd1 || first_err_vec !== 2'd3) begin
      errors++;
      $display("FAIL done_prestart got flags %b err %0d vec %0d exp 010 err 1 vec 3",
               {busy, done, pass}, err_cnt, first_err_vec);
    end
    do_start(1'b0, 2'd0, 1'b0);
    sample(1'b1, 2'd0, 1'b0);
    sample(1'b1, 2'd1, 1'b1);
    start = 1'b1;
    sample(1'b1, 2'd2, 1'b1);
    sample(1'b1, 2'd3, 1'b0);
    start = 1'b0;
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++;
      $display("FAIL start_beats_complete got busy/done %b exp 10", {busy, done});
    end
    sample(1'b1, 2'd3, 1'b1);
    checks++;
    if (err_cnt !== 8'd1 || first_err_vec !== 2'd3 || first_err_vld !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre got err %0d vec %0d vld %b exp err 1 vec 3 vld 1",
               err_cnt, first_err_vec, first_err_vld);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, pass, first_err_vld, seq_err} !== 5'b00000 || err_cnt !== 8'd0 || first_err_vec !== 2'd0) begin
      errors++;
      $display("FAIL async_reset got flags %b err %0d vec %0d exp 00000 err 0 vec 0",
               {busy, done, pass, first_err_vld, seq_err}, err_cnt, first_err_vec);
    end
    rst_n = 1'b1;
    sample(1'b1, 2'd0, 1'b1);
    checks++;
    if ({busy, done} !== 2'b00 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL post_reset_idle got busy/done %b err %0d exp 00 err 0", {busy, done}, err_cnt);
    end
  endtask

  task automatic test_order();
    do_start(1'b0, 2'd0, 1'b0);
    sample(1'b1, 2'd0, 1'b0);
    checks++;
    if (seq_err !== 1'b0) begin
      errors++;
      $display("FAIL order_first got seq_err %b exp 0", seq_err);
    end
    sample(1'b1, 2'd2, 1'b1);
    checks++;
    if (seq_err !== SEQ_EN) begin
      errors++;
      $display("FAIL order_jump got seq_err %b exp %b", seq_err, SEQ_EN);
    end
    sample(1'b1, 2'd3, 1'b0);
    sample(1'b1, 2'd1, 1'b1);
    checks++;
    if ({busy, done, pass, seq_err} !== {3'b011, SEQ_EN} || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL order_done got flags %b err %0d exp %b err 0",
               {busy, done, pass, seq_err}, err_cnt, {3'b011, SEQ_EN});
    end
    do_start(1'b0, 2'd0, 1'b0);
    checks++;
    if (seq_err !== 1'b0) begin
      errors++;
      $display("FAIL order_clear got seq_err %b exp 0", seq_err);
    end
    sample(1'b1, 2'd3, 1'b0);
    sample(1'b1, 2'd0, 1'b0);
    sample(1'b1, 2'd1, 1'b1);
    checks++;
    if (seq_err !== 1'b0) begin
      errors++;
      $display("FAIL order_wrap got seq_err %b exp 0", seq_err);
    end
  endtask

  initial begin
    test_reset();
    test_clean_sweep();
    test_single_fault();
    test_incomplete();
    test_saturation();
    test_restart_and_reset();
    test_order();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
